// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key scheduler: expands the cipher key forward to round key 10,
// then walks the schedule backwards, emitting round keys 10..0 over valid/ready.
module aes_inv_key_sched #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key_in,
    input  logic         flush,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and rk_out/rk_round hold while stalled.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t            state_q, state_d;
    logic [32*NK-1:0]  work_q;
    logic [3:0]        ctr_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(a, a);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    logic [31:0]  w0, w1, w2, w3, w3_prev, sbox_in, t_word;
    logic [127:0] fwd_key, inv_key;
    logic [31:0]  f0, f1, f2, f3;

    assign w0 = work_q[127:96];
    assign w1 = work_q[95:64];
    assign w2 = work_q[63:32];
    assign w3 = work_q[31:0];

    // Single S-box bank: forward step uses w3, inverse step uses the recovered w3'.
    assign w3_prev = w3 ^ w2;
    assign sbox_in = (state_q == EXPAND) ? w3 : w3_prev;
    assign t_word  = sub_word({sbox_in[23:0], sbox_in[31:24]}) ^ rcon(ctr_q);

    assign f0      = w0 ^ t_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3_prev};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (key_valid) state_d = EXPAND;
                EXPAND:  if (ctr_q == LAST_ROUND) state_d = EMIT;
                EMIT:    if (rk_ready && ctr_q == 4'd0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // In EXPAND ctr_q is the forward round being built; in EMIT it is rk_round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            ctr_q  <= 4'd0;
        end else if (flush) begin
            ctr_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        work_q <= key_in;
                        ctr_q  <= 4'd1;
                    end
                end
                EXPAND: begin
                    work_q <= fwd_key;
                    if (ctr_q != LAST_ROUND) ctr_q <= ctr_q + 4'd1;
                end
                EMIT: begin
                    if (rk_ready && ctr_q != 4'd0) begin
                        work_q <= inv_key;
                        ctr_q  <= ctr_q - 4'd1;
                    end
                end
                default: ctr_q <= 4'd0;
            endcase
        end
    end

    always_comb begin
        key_ready = (state_q == IDLE);
        rk_valid  = (state_q == EMIT);
        busy      = (state_q != IDLE);
        rk_out    = rk_valid ? work_q : '0;
        rk_round  = rk_valid ? ctr_q : 4'd0;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 key expansion vectors.
module tb_aes_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key_in;
    logic         flush;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    aes_inv_key_sched #(.NK(4), .NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .flush     (flush),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS-197 round keys for KEY_A.
    function automatic logic [127:0] exp_a(input int r);
        case (r)
            0:       return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:       return 128'ha0fafe1788542cb123a339392a6c7605;
            2:       return 128'hf2c295f27a96b9435935807a7359f67f;
            3:       return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:       return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:       return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:       return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:       return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:       return 128'head27321b58dbad2312bf5607f8d292f;
            9:       return 128'hac7766f319fadc2128d12941575c006e;
            10:      return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: return 128'h0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!rk_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 100", {key_ready, rk_valid, busy});
        end
        n_checks++;
        if (rk_out !== 128'h0 || rk_round !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_out got %h/%0d want 0/0", rk_out, rk_round);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream_a;
        int cyc;
        rk_ready = 1'b1;
        load_key(KEY_A);
        wait_valid(cyc);
        n_checks++;
        if (cyc != 10) begin
            n_errors++;
            $display("FAIL stream_latency got %0d want 10", cyc);
        end
        for (int r = 10; r >= 0; r--) exp_q.push_back(exp_a(r));
        for (int r = 10; r >= 0; r--) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== e) begin
                n_errors++;
                $display("FAIL stream_beat v=%b round got %0d want %0d key got %h want %h",
                         rk_valid, rk_round, r, rk_out, e);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL stream_idle got %b want 100", {key_ready, rk_valid, busy});
        end
    endtask

    task automatic test_stall;
        int cyc, beats, exp_round, stall_cnt;
        rk_ready = 1'b0;
        load_key(KEY_A);
        wait_valid(cyc);
        beats     = 0;
        exp_round = 10;
        stall_cnt = 0;
        cyc       = 0;
        while (beats < 11 && cyc < 400) begin
            cyc++;
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(exp_round) || rk_out !== exp_a(exp_round)) begin
                n_errors++;
                $display("FAIL stall_beat v=%b round got %0d want %0d key got %h want %h",
                         rk_valid, rk_round, exp_round, rk_out, exp_a(exp_round));
                break;
            end
            if ((exp_round == 10 || exp_round == 5 || exp_round == 0) && stall_cnt < 5) begin
                rk_ready = 1'b0;
                stall_cnt++;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            if (rk_ready) begin
                beats++;
                exp_round--;
                stall_cnt = 0;
            end
            @(posedge clk);
            #1;
        end
        rk_ready = 1'b0;
        n_checks++;
        if (beats != 11) begin
            n_errors++;
            $display("FAIL stall_beats got %0d want 11", beats);
        end
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL stall_idle got %b want 100", {key_ready, rk_valid, busy});
        end
    endtask

    task automatic test_zero_key;
        int cyc;
        rk_ready = 1'b1;
        load_key(KEY_ZERO);
        wait_valid(cyc);
        for (int r = 10; r >= 0; r--) begin
            n_checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r)) begin
                n_errors++;
                $display("FAIL zero_round got v=%b r=%0d want r=%0d", rk_valid, rk_round, r);
            end
            if (r == 10) begin
                n_checks++;
                if (rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
                    n_errors++;
                    $display("FAIL zero_rk10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", rk_out);
                end
            end
            if (r == 1) begin
                n_checks++;
                if (rk_out !== 128'h62636363626363636263636362636363) begin
                    n_errors++;
                    $display("FAIL zero_rk1 got %h want 62636363626363636263636362636363", rk_out);
                end
            end
            if (r == 0) begin
                n_checks++;
                if (rk_out !== 128'h0) begin
                    n_errors++;
                    $display("FAIL zero_rk0 got %h want 0", rk_out);
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (key_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_idle key_ready got %b want 1", key_ready);
        end
    endtask

    task automatic test_key_ignored;
        int cyc;
        rk_ready = 1'b0;
        load_key(KEY_A);
        repeat (3) @(posedge clk);
        #1;
        key_in    = KEY_ZERO;
        key_valid = 1'b1;
        n_checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL ign_expand_ready got kr=%b busy=%b want 0/1", key_ready, busy);
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_valid(cyc);
        rk_ready = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            key_valid = (r == 7);
            n_checks++;
            if (rk_valid !== 1'b1 || key_ready !== 1'b0 || rk_round !== 4'(r) || rk_out !== exp_a(r)) begin
                n_errors++;
                $display("FAIL ign_beat v=%b kr=%b round got %0d want %0d key got %h want %h",
                         rk_valid, key_ready, rk_round, r, rk_out, exp_a(r));
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL ign_idle got %b want 100", {key_ready, rk_valid, busy});
        end
    endtask

    task automatic test_flush;
        int cyc;
        rk_ready = 1'b1;
        load_key(KEY_A);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_pre_busy got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100 || rk_round !== 4'd0) begin
            n_errors++;
            $display("FAIL flush_expand got %b r=%0d want 100 r=0", {key_ready, rk_valid, busy}, rk_round);
        end
        load_key(KEY_A);
        wait_valid(cyc);
        cyc = 0;
        while (rk_round != 4'd6 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (rk_round !== 4'd6 || rk_out !== exp_a(6)) begin
            n_errors++;
            $display("FAIL flush_reach6 got r=%0d key %h want r=6 key %h", rk_round, rk_out, exp_a(6));
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100 || rk_round !== 4'd0 || rk_out !== 128'h0) begin
            n_errors++;
            $display("FAIL flush_emit got %b r=%0d key %h want 100 r=0 key 0",
                     {key_ready, rk_valid, busy}, rk_round, rk_out);
        end
        key_in    = KEY_ZERO;
        key_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        flush     = 1'b0;
        n_checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle_load got kr=%b busy=%b want 1/0", key_ready, busy);
        end
        load_key(KEY_A);
        wait_valid(cyc);
        n_checks++;
        if (cyc != 10 || rk_round !== 4'd10 || rk_out !== exp_a(10)) begin
            n_errors++;
            $display("FAIL flush_reload got cyc=%0d r=%0d key %h want cyc=10 r=10 key %h",
                     cyc, rk_round, rk_out, exp_a(10));
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_async_reset;
        int cyc;
        rk_ready = 1'b1;
        load_key(KEY_A);
        wait_valid(cyc);
        cyc = 0;
        while (rk_round != 4'd3 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rk_round !== 4'd3 || rk_out !== exp_a(3)) begin
            n_errors++;
            $display("FAIL arst_hold got r=%0d key %h want r=3 key %h", rk_round, rk_out, exp_a(3));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100 || rk_round !== 4'd0 || rk_out !== 128'h0) begin
            n_errors++;
            $display("FAIL arst_now got %b r=%0d key %h want 100 r=0 key 0",
                     {key_ready, rk_valid, busy}, rk_round, rk_out);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({key_ready, rk_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL arst_after got %b want 100", {key_ready, rk_valid, busy});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        key_valid = 1'b0;
        key_in    = '0;
        flush     = 1'b0;
        rk_ready  = 1'b0;
        test_reset();
        test_stream_a();
        test_stall();
        test_zero_key();
        test_key_ignored();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
